// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one 1-bit full-subtractor cell evaluated per clock,
// sequenced by a start/busy/done handshake with registered results.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one cell evaluation per edge, LSB first, WIDTH edges total
// DONE  | results valid, done pulses for one cycle, then back to IDLE
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             load, step, last;

  logic [WIDTH-1:0] a_sr, b_sr, d_sr;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a_msb, b_msb;

  logic             x, y, d, bo;
  logic [WIDTH-1:0] d_final;

  assign x       = a_sr[0];
  assign y       = b_sr[0];
  assign d       = x ^ y ^ br;
  assign bo      = (~x & y) | (~(x ^ y) & br);
  assign d_final = {d, d_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      d_sr  <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b;
      br    <= bin;
      cnt   <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (step) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      d_sr <= d_final;
      br   <= bo;
      cnt  <= cnt + 1'b1;
    end
  end

  // Result registers only move on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else if (last) begin
      diff   <= d_final;
      borrow <= bo;
      ovf    <= (a_msb != b_msb) && (d != a_msb);
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: directed WIDTH=8 vectors plus an
// exhaustive WIDTH=2 sweep, expected results queued at issue time.
module tb_serial_sub_ctrl;

  typedef struct {
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, borrow8, ovf8;
  logic [7:0] diff8;
  logic       start2 = 1'b0, bin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, borrow2, ovf2;
  logic [1:0] diff2;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q8[$];
  exp_t q2[$];
  logic prev8 = 1'b0, prev2 = 1'b0;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .ovf(ovf8)
  );

  serial_sub_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .borrow(borrow2), .ovf(ovf2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done8) begin
        exp_t e;
        chk("done8_not_consecutive", {31'd0, prev8}, 32'd0);
        if (q8.size() == 0) begin
          chk("done8_unexpected", 32'd1, {31'd0, busy8 & 1'b0});
        end else begin
          e = q8.pop_front();
          chk("diff8", {24'd0, diff8}, e.diff);
          chk("borrow8", {31'd0, borrow8}, {31'd0, e.borrow});
          chk("ovf8", {31'd0, ovf8}, {31'd0, e.ovf});
          chk("done8_cycle", cyc, e.cyc);
        end
      end
      if (done2) begin
        exp_t e;
        chk("done2_not_consecutive", {31'd0, prev2}, 32'd0);
        if (q2.size() == 0) begin
          chk("done2_unexpected", 32'd1, {31'd0, busy2 & 1'b0});
        end else begin
          e = q2.pop_front();
          chk("diff2", {30'd0, diff2}, e.diff);
          chk("borrow2", {31'd0, borrow2}, {31'd0, e.borrow});
          chk("ovf2", {31'd0, ovf2}, {31'd0, e.ovf});
          chk("done2_cycle", cyc, e.cyc);
        end
      end
    end
    prev8 = done8;
    prev2 = done2;
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ed, input logic eb, input logic eo,
                        output int busy_cycles);
    int n;
    @(posedge clk); #1;
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    q8.push_back('{diff: {24'd0, ed}, borrow: eb, ovf: eo, cyc: cyc + 1 + 8});
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy8) break;
      n++;
    end
    busy_cycles = n;
    if (busy8) chk("issue8_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle8(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy8 && q8.size() == 0) break;
    end
    chk(name, q8.size(), 32'd0);
  endtask

  initial begin
    int bc;
    int k;
    #1 chk("reset_busy8", {31'd0, busy8}, 32'd0);
    chk("reset_done8", {31'd0, done8}, 32'd0);
    chk("reset_diff8", {24'd0, diff8}, 32'd0);
    chk("reset_borrow8", {31'd0, borrow8}, 32'd0);
    chk("reset_ovf8", {31'd0, ovf8}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    issue8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, bc);
    chk("busy_cycles_5a_3c", bc, 32'd9);
    issue8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, bc);
    chk("busy_cycles_00_01", bc, 32'd9);
    issue8(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0, bc);
    issue8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, bc);
    issue8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, bc);

    // Reset four edges into a run; previous result 0x80/1/1 must clear at once.
    @(posedge clk); #1;
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    q8.delete();
    #1;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_diff", {24'd0, diff8}, 32'd0);
    chk("abort_borrow", {31'd0, borrow8}, 32'd0);
    chk("abort_ovf", {31'd0, ovf8}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_abort_idle", {31'd0, busy8}, 32'd0);
    issue8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, bc);
    chk("busy_cycles_after_abort", bc, 32'd9);

    // Start pulsed again mid-run with new operands: ignored.
    @(posedge clk); #1;
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back('{diff: 32'h1E, borrow: 1'b0, ovf: 1'b0, cyc: cyc + 1 + 8});
    @(posedge clk); #1 start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1 a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    wait_idle8("overlap_drain");
    repeat (6) @(negedge clk);

    // start held high: second operation accepted at E0+10.
    @(posedge clk); #1;
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
    k = cyc;
    q8.push_back('{diff: 32'h1E, borrow: 1'b0, ovf: 1'b0, cyc: k + 9});
    q8.push_back('{diff: 32'hFF, borrow: 1'b1, ovf: 1'b0, cyc: k + 19});
    @(posedge clk); #1 a8 = 8'h00; b8 = 8'h01;
    while (cyc < k + 11) @(posedge clk);
    #1 start8 = 1'b0;
    wait_idle8("b2b_drain");

    // WIDTH=2 exhaustive sweep against an arithmetic model.
    for (int av = 0; av < 4; av++) begin
      for (int bv = 0; bv < 4; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          int sa, sb, r;
          sa = (av >= 2) ? av - 4 : av;
          sb = (bv >= 2) ? bv - 4 : bv;
          r  = sa - sb - cv;
          @(posedge clk); #1;
          a2 = 2'(av); b2 = 2'(bv); bin2 = 1'(cv); start2 = 1'b1;
          q2.push_back('{diff: 32'((av - bv - cv) & 3), borrow: (av < bv + cv),
                         ovf: (r < -2 || r > 1), cyc: cyc + 1 + 2});
          @(posedge clk); #1 start2 = 1'b0;
          for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy2) break;
          end
        end
      end
    end
    repeat (3) @(negedge clk);
    chk("sweep2_drain", q2.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
